gshare_bp_param: RTL and testbench

GSHARE_BP_PARAM -- requirements
Module: gshare_bp_param

---
 rtl/gshare_bp_param.sv | 192 +++++++++++++++++++
 tb/tb_gshare_bp_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_bp_param.sv
// Gshare branch predictor: 2-bit counter table indexed by PC xor global history.
// Define GSHARE_STATS_EN to add the stat_lookups / stat_mispredicts counters.
`timescale 1ns/1ps
module gshare_bp_param #(
    parameter int unsigned PC_BITS    = 32,
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned GHR_BITS   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pred_valid,
    input  logic [PC_BITS-1:0]  pred_pc,
    input  logic [6:0]          pred_opcode,
    output logic                pred_ready,
    output logic                pred_out_valid,
    output logic                pred_taken,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [PC_BITS-1:0]  upd_pc,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_taken,
    input  logic                upd_mispredict
`ifdef GSHARE_STATS_EN
    ,
    output logic [31:0]         stat_lookups,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam int unsigned Depth = 1 << INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LastIdx = INDEX_BITS'(Depth - 1);

    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                state_q, state_d;
    logic [INDEX_BITS-1:0] init_ptr_q, init_ptr_d;
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;
    logic                  out_valid_q;
    logic                  taken_q;
    logic [GHR_BITS-1:0]   ghr_out_q;

    logic [1:0]            pht [Depth];

    logic                  run;
    logic                  lookup_fire;
    logic                  upd_fire;
    logic                  recover;
    logic                  is_cond;
    logic                  is_jump;
    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [1:0]            pred_ctr;
    logic [1:0]            upd_ctr_old;
    logic [1:0]            upd_ctr_new;
    logic                  lookup_taken;
    logic                  unused_bits;

    assign run         = (state_q == StRun);
    assign lookup_fire = pred_valid & run;
    assign upd_fire    = upd_valid & run;
    assign recover     = upd_fire & upd_mispredict;

    // Only the index slice of each PC participates in the hash.
    assign unused_bits = ^{pred_pc, upd_pc};

    assign pred_idx = pred_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
    assign upd_idx  = upd_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(upd_ghr);

    assign pred_ctr    = pht[pred_idx];
    assign upd_ctr_old = pht[upd_idx];

    assign is_cond = (pred_opcode == OpBranch);
    assign is_jump = (pred_opcode == OpJal) || (pred_opcode == OpJalr);

    always_comb begin
        lookup_taken = 1'b0;
        if (is_cond) begin
            lookup_taken = pred_ctr[1];
        end else if (is_jump) begin
            lookup_taken = 1'b1;
        end
    end

    always_comb begin
        upd_ctr_new = upd_ctr_old;
        if (upd_taken) begin
            if (upd_ctr_old != 2'b11) begin
                upd_ctr_new = upd_ctr_old + 2'b01;
            end
        end else begin
            if (upd_ctr_old != 2'b00) begin
                upd_ctr_new = upd_ctr_old - 2'b01;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        unique case (state_q)
            StInit: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == LastIdx) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // Recovery overrides the speculative shift of a same-cycle lookup.
    always_comb begin
        ghr_d = ghr_q;
        if (recover) begin
            ghr_d = GHR_BITS'({upd_ghr, upd_taken});
        end else if (lookup_fire && is_cond) begin
            ghr_d = GHR_BITS'({ghr_q, lookup_taken});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            init_ptr_q <= '0;
            ghr_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            ghr_q      <= ghr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            ghr_out_q   <= '0;
        end else begin
            out_valid_q <= lookup_fire;
            if (lookup_fire) begin
                taken_q   <= lookup_taken;
                ghr_out_q <= ghr_q;
            end
        end
    end

    // Table contents are rebuilt by the init sweep, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (!run) begin
            pht[init_ptr_q] <= 2'b01;
        end else if (upd_valid) begin
            pht[upd_idx] <= upd_ctr_new;
        end
    end

    assign pred_ready     = run;
    assign pred_out_valid = out_valid_q;
    assign pred_taken     = taken_q;
    assign pred_ghr       = ghr_out_q;

`ifdef GSHARE_STATS_EN
    logic [31:0] lookups_q;
    logic [31:0] mispredicts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookups_q     <= '0;
            mispredicts_q <= '0;
        end else begin
            if (lookup_fire && (lookups_q != 32'hFFFF_FFFF)) begin
                lookups_q <= lookups_q + 32'd1;
            end
            if (recover && (mispredicts_q != 32'hFFFF_FFFF)) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_mispredicts = mispredicts_q;
`endif

endmodule

// File: tb/tb_gshare_bp_param.sv
// Directed bench for gshare_bp_param: vector table plus init/reset sequences.
`timescale 1ns/1ps
module tb_gshare_bp_param;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic        clk;
    logic        rst_n;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic [6:0]  pred_opcode;
    logic        pred_ready;
    logic        pred_out_valid;
    logic        pred_taken;
    logic [7:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [7:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;
`ifdef GSHARE_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;
`endif

    gshare_bp_param #(
        .PC_BITS   (32),
        .INDEX_BITS(8),
        .GHR_BITS  (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pred_valid    (pred_valid),
        .pred_pc       (pred_pc),
        .pred_opcode   (pred_opcode),
        .pred_ready    (pred_ready),
        .pred_out_valid(pred_out_valid),
        .pred_taken    (pred_taken),
        .pred_ghr      (pred_ghr),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_ghr       (upd_ghr),
        .upd_taken     (upd_taken),
        .upd_mispredict(upd_mispredict)
`ifdef GSHARE_STATS_EN
        ,
        .stat_lookups    (stat_lookups),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        lk;
        logic [31:0] pc;
        logic [6:0]  op;
        logic        up;
        logic [31:0] upc;
        logic [7:0]  ughr;
        logic        ut;
        logic        um;
        logic        ev;
        logic        et;
        logic [7:0]  eg;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic lk, input logic [31:0] pc, input logic [6:0] op,
                                input logic up, input logic [31:0] upc, input logic [7:0] ughr,
                                input logic ut, input logic um,
                                input logic ev, input logic et, input logic [7:0] eg);
        vec_t v;
        v.lk = lk; v.pc = pc; v.op = op;
        v.up = up; v.upc = upc; v.ughr = ughr; v.ut = ut; v.um = um;
        v.ev = ev; v.et = et; v.eg = eg;
        return v;
    endfunction

    task automatic idle_inputs();
        pred_valid     = 1'b0;
        pred_pc        = '0;
        pred_opcode    = OP_ALU;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_ghr        = '0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        pred_valid     = v.lk;
        pred_pc        = v.pc;
        pred_opcode    = v.op;
        upd_valid      = v.up;
        upd_pc         = v.upc;
        upd_ghr        = v.ughr;
        upd_taken      = v.ut;
        upd_mispredict = v.um;
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, {31'd0, pred_out_valid}, {31'd0, v.ev});
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, v.et});
        chk({tag, ".ghr"}, {24'd0, pred_ghr}, {24'd0, v.eg});
        idle_inputs();
    endtask

    // Waits for pred_ready from a point where rst_n was just released; counts low cycles.
    task automatic wait_init(output int cnt, output int ov_seen);
        cnt     = 0;
        ov_seen = 0;
        while (!pred_ready && cnt < 1000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (pred_out_valid) ov_seen++;
        end
    endtask

    vec_t vecs[28];
    vec_t post[5];
    int   cnt;
    int   ov_seen;

    initial begin
        vecs[0]  = mk(1, 32'h40,  OP_BR,   0, 32'h0,  8'h00, 0, 0, 1, 0, 8'h00);
        vecs[1]  = mk(0, 32'h0,   OP_ALU,  1, 32'h40, 8'h00, 1, 0, 0, 0, 8'h00);
        vecs[2]  = mk(0, 32'h0,   OP_ALU,  1, 32'h40, 8'h00, 1, 0, 0, 0, 8'h00);
        vecs[3]  = mk(1, 32'h40,  OP_BR,   0, 32'h0,  8'h00, 0, 0, 1, 1, 8'h00);
        vecs[4]  = mk(1, 32'h40,  OP_BR,   0, 32'h0,  8'h00, 0, 0, 1, 0, 8'h01);
        vecs[5]  = mk(1, 32'h100, OP_JAL,  0, 32'h0,  8'h00, 0, 0, 1, 1, 8'h02);
        vecs[6]  = mk(1, 32'h100, OP_JALR, 0, 32'h0,  8'h00, 0, 0, 1, 1, 8'h02);
        vecs[7]  = mk(1, 32'h100, OP_ALU,  0, 32'h0,  8'h00, 0, 0, 1, 0, 8'h02);
        vecs[8]  = mk(1, 32'h40,  OP_BR,   0, 32'h0,  8'h00, 0, 0, 1, 0, 8'h02);
        // Saturation at index 0x20 (upd_pc 0x80, upd_ghr 0).
        for (int i = 9; i <= 12; i++) begin
            vecs[i] = mk(0, 32'h0, OP_ALU, 1, 32'h80, 8'h00, 1, 0, 0, 0, 8'h02);
        end
        vecs[13] = mk(0, 32'h0,   OP_ALU,  1, 32'h80, 8'h00, 0, 0, 0, 0, 8'h02);
        vecs[14] = mk(1, 32'h90,  OP_BR,   0, 32'h0,  8'h00, 0, 0, 1, 1, 8'h04);
        for (int i = 15; i <= 18; i++) begin
            vecs[i] = mk(0, 32'h0, OP_ALU, 1, 32'h80, 8'h00, 0, 0, 0, 1, 8'h04);
        end
        vecs[19] = mk(1, 32'hA4,  OP_BR,   0, 32'h0,  8'h00, 0, 0, 1, 0, 8'h09);
        vecs[20] = mk(0, 32'h0,   OP_ALU,  1, 32'h80, 8'h00, 1, 0, 0, 0, 8'h09);
        vecs[21] = mk(1, 32'hC8,  OP_BR,   0, 32'h0,  8'h00, 0, 0, 1, 0, 8'h12);
        vecs[22] = mk(0, 32'h0,   OP_ALU,  1, 32'h80, 8'h00, 1, 0, 0, 0, 8'h12);
        vecs[23] = mk(1, 32'h10,  OP_BR,   0, 32'h0,  8'h00, 0, 0, 1, 1, 8'h24);
        // Same-cycle lookup and update on index 0x20: lookup sees pre-update counter.
        vecs[24] = mk(1, 32'h1A4, OP_BR,   1, 32'h80, 8'h00, 0, 0, 1, 1, 8'h49);
        vecs[25] = mk(1, 32'h2CC, OP_BR,   0, 32'h0,  8'h00, 0, 0, 1, 0, 8'h93);
        // Mispredict recovery with a same-cycle lookup.
        vecs[26] = mk(1, 32'h40,  OP_BR,   1, 32'h0,  8'h05, 1, 1, 1, 0, 8'h26);
        vecs[27] = mk(1, 32'h0,   OP_BR,   0, 32'h0,  8'h00, 0, 0, 1, 0, 8'h0B);

        post[0]  = mk(1, 32'h100, OP_JAL,  0, 32'h0,  8'h00, 0, 0, 1, 1, 8'h00);
        post[1]  = mk(1, 32'h100, OP_JALR, 0, 32'h0,  8'h00, 0, 0, 1, 1, 8'h00);
        post[2]  = mk(1, 32'h40,  OP_BR,   0, 32'h0,  8'h00, 0, 0, 1, 0, 8'h00);
        post[3]  = mk(1, 32'h14,  OP_BR,   0, 32'h0,  8'h00, 0, 0, 1, 0, 8'h00);
        post[4]  = mk(1, 32'h80,  OP_BR,   0, 32'h0,  8'h00, 0, 0, 1, 0, 8'h00);

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.ready", {31'd0, pred_ready}, 32'd0);
        chk("rst.out_valid", {31'd0, pred_out_valid}, 32'd0);
        chk("rst.taken", {31'd0, pred_taken}, 32'd0);
        chk("rst.ghr", {24'd0, pred_ghr}, 32'd0);

        // Lookups and a recovery update offered during init must be ignored.
        rst_n          = 1'b1;
        pred_valid     = 1'b1;
        pred_opcode    = OP_JAL;
        upd_valid      = 1'b1;
        upd_pc         = 32'h40;
        upd_ghr        = 8'hFF;
        upd_taken      = 1'b1;
        upd_mispredict = 1'b1;
        wait_init(cnt, ov_seen);
        idle_inputs();
        chk("init.low_cycles", cnt, 32'd256);
        chk("init.out_valid_seen", ov_seen, 32'd0);
        chk("init.ready_after", {31'd0, pred_ready}, 32'd1);

        for (int i = 0; i < 28; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset mid-run while an output is valid.
        apply("pre_rst", mk(1, 32'h100, OP_JAL, 0, 32'h0, 8'h00, 0, 0, 1, 1, 8'h16));
        apply("pre_rst2", mk(1, 32'h100, OP_JAL, 0, 32'h0, 8'h00, 0, 0, 1, 1, 8'h16));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.ready", {31'd0, pred_ready}, 32'd0);
        chk("mid_rst.out_valid", {31'd0, pred_out_valid}, 32'd0);
        chk("mid_rst.taken", {31'd0, pred_taken}, 32'd0);
        chk("mid_rst.ghr", {24'd0, pred_ghr}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_init(cnt, ov_seen);
        chk("reinit.low_cycles", cnt, 32'd256);
        chk("reinit.out_valid_seen", ov_seen, 32'd0);

        for (int i = 0; i < 5; i++) begin
            apply($sformatf("post%0d", i), post[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
